// File: rtl/tile_walker.sv
// Tile-locked overworld player controller: W/A/S/D keycodes become one-tile steps,
// each checked against the collision ROM and animated one pixel per video frame.
module tile_walker #(
  parameter int unsigned TILE_SIZE = 16,
  parameter int unsigned MAP_W     = 40,
  parameter int unsigned MAP_H     = 30,
  parameter int unsigned START_TX  = 20,
  parameter int unsigned START_TY  = 15,
  parameter int unsigned ANIM_DIV  = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  output logic       query_valid,
  output logic [5:0] query_tx,
  output logic [4:0] query_ty,
  input  logic       wall_hit,
  output logic [9:0] PlayerX,
  output logic [9:0] PlayerY,
  output logic [1:0] facing,
  output logic [1:0] walk_frame,
  output logic       moving
);

  localparam int unsigned STEP_W = $clog2(TILE_SIZE);
  localparam int unsigned ANIM_W = $clog2(ANIM_DIV);

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_WALK
  } state_t;

  state_t state_q, state_d;

  logic              vs_q;
  logic [5:0]        tx_q, tx_d;
  logic [4:0]        ty_q, ty_d;
  logic [9:0]        px_q, px_d;
  logic [9:0]        py_q, py_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
  logic [1:0]        facing_q, facing_d;
  logic [1:0]        wf_q, wf_d;
  logic              moving_q, moving_d;
  logic              qv_q, qv_d;
  logic [5:0]        qtx_q, qtx_d;
  logic [4:0]        qty_q, qty_d;

  logic       tick;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       in_bounds;
  logic [5:0] tgt_tx;
  logic [4:0] tgt_ty;
  logic       step_last;
  logic       anim_last;

  // Falling edge of the raw active-low vsync gives exactly one tick per frame.
  assign tick      = vs_q & ~vsync;
  assign step_last = (step_cnt_q == STEP_W'(TILE_SIZE - 1));
  assign anim_last = (anim_cnt_q == ANIM_W'(ANIM_DIV - 1));

  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_DOWN;
    case (keycode)
      8'h1A:   key_dir = DIR_UP;
      8'h16:   key_dir = DIR_DOWN;
      8'h04:   key_dir = DIR_LEFT;
      8'h07:   key_dir = DIR_RIGHT;
      default: key_valid = 1'b0;
    endcase
  end

  always_comb begin
    in_bounds = 1'b0;
    tgt_tx    = tx_q;
    tgt_ty    = ty_q;
    case (key_dir)
      DIR_DOWN: begin
        in_bounds = (ty_q != 5'(MAP_H - 1));
        tgt_ty    = ty_q + 5'd1;
      end
      DIR_UP: begin
        in_bounds = (ty_q != '0);
        tgt_ty    = ty_q - 5'd1;
      end
      DIR_LEFT: begin
        in_bounds = (tx_q != '0);
        tgt_tx    = tx_q - 6'd1;
      end
      default: begin
        in_bounds = (tx_q != 6'(MAP_W - 1));
        tgt_tx    = tx_q + 6'd1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick && key_valid && in_bounds) state_d = S_QUERY;
      S_QUERY: state_d = S_WAIT;
      S_WAIT:  state_d = wall_hit ? S_IDLE : S_WALK;
      S_WALK:  if (tick && step_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d       = tx_q;
    ty_d       = ty_q;
    px_d       = px_q;
    py_d       = py_q;
    step_cnt_d = step_cnt_q;
    anim_cnt_d = anim_cnt_q;
    facing_d   = facing_q;
    wf_d       = wf_q;
    qv_d       = 1'b0;
    qtx_d      = qtx_q;
    qty_d      = qty_q;
    case (state_q)
      S_IDLE: begin
        if (tick && key_valid) begin
          facing_d = key_dir;
          if (in_bounds) begin
            qtx_d = tgt_tx;
            qty_d = tgt_ty;
            qv_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        step_cnt_d = '0;
        anim_cnt_d = '0;
        wf_d       = '0;
      end
      S_WALK: begin
        if (tick) begin
          case (facing_q)
            DIR_DOWN: py_d = py_q + 10'd1;
            DIR_UP:   py_d = py_q - 10'd1;
            DIR_LEFT: px_d = px_q - 10'd1;
            default:  px_d = px_q + 10'd1;
          endcase
          step_cnt_d = step_cnt_q + 1'b1;
          anim_cnt_d = anim_cnt_q + 1'b1;
          if (anim_last) wf_d = wf_q + 2'd1;
          // The query target doubles as the step destination, committed on the last pixel.
          if (step_last) begin
            tx_d = qtx_q;
            ty_d = qty_q;
            wf_d = '0;
          end
        end
      end
      default: ;
    endcase
    moving_d = (state_d == S_WALK);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q       <= 1'b1;
      tx_q       <= 6'(START_TX);
      ty_q       <= 5'(START_TY);
      px_q       <= 10'(START_TX * TILE_SIZE);
      py_q       <= 10'(START_TY * TILE_SIZE);
      step_cnt_q <= '0;
      anim_cnt_q <= '0;
      facing_q   <= DIR_DOWN;
      wf_q       <= '0;
      moving_q   <= 1'b0;
      qv_q       <= 1'b0;
      qtx_q      <= '0;
      qty_q      <= '0;
    end else begin
      vs_q       <= vsync;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      px_q       <= px_d;
      py_q       <= py_d;
      step_cnt_q <= step_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      facing_q   <= facing_d;
      wf_q       <= wf_d;
      moving_q   <= moving_d;
      qv_q       <= qv_d;
      qtx_q      <= qtx_d;
      qty_q      <= qty_d;
    end
  end

  assign query_valid = qv_q;
  assign query_tx    = qtx_q;
  assign query_ty    = qty_q;
  assign PlayerX     = px_q;
  assign PlayerY     = py_q;
  assign facing      = facing_q;
  assign walk_frame  = wf_q;
  assign moving      = moving_q;

endmodule

// File: tb/tb_tile_walker.sv
// Scoreboard bench for tile_walker: expected queries and pixel moves are queued by the
// stimulus and consumed by a monitor whenever the DUT pulses a query or moves the sprite.
module tb_tile_walker;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vsync;
  logic [7:0] keycode;
  logic       query_valid;
  logic [5:0] query_tx;
  logic [4:0] query_ty;
  logic       wall_hit;
  logic [9:0] PlayerX;
  logic [9:0] PlayerY;
  logic [1:0] facing;
  logic [1:0] walk_frame;
  logic       moving;

  tile_walker #(
    .TILE_SIZE(16),
    .MAP_W(40),
    .MAP_H(30),
    .START_TX(20),
    .START_TY(15),
    .ANIM_DIV(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .vsync(vsync),
    .keycode(keycode),
    .query_valid(query_valid),
    .query_tx(query_tx),
    .query_ty(query_ty),
    .wall_hit(wall_hit),
    .PlayerX(PlayerX),
    .PlayerY(PlayerY),
    .facing(facing),
    .walk_frame(walk_frame),
    .moving(moving)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  logic        mon_en = 1'b0;
  logic [10:0] qq[$];
  logic [22:0] mq[$];
  logic [19:0] last_pos;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_move(input int x, input int y, input int wf, input int mv);
    mq.push_back({10'(x), 10'(y), 2'(wf), 1'(mv)});
  endtask

  task automatic push_query(input int tx, input int ty);
    qq.push_back({6'(tx), 5'(ty)});
  endtask

  // One frame: vsync low for one cycle, then enough cycles for QUERY/WAIT to resolve.
  task automatic tick_frame();
    @(negedge Clk) vsync = 1'b0;
    @(negedge Clk) vsync = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  always @(negedge Clk) begin
    logic [10:0] eq;
    logic [22:0] em;
    if (mon_en) begin
      if (query_valid) begin
        if (qq.size() == 0) check("query_unexpected", 1, 0);
        else begin
          eq = qq.pop_front();
          check("query_tx", int'(query_tx), int'(eq[10:5]));
          check("query_ty", int'(query_ty), int'(eq[4:0]));
        end
      end
      if ({PlayerX, PlayerY} !== last_pos) begin
        if (mq.size() == 0) check("move_unexpected", int'(PlayerX) * 1024 + int'(PlayerY), -1);
        else begin
          em = mq.pop_front();
          check("move_x", int'(PlayerX), int'(em[22:13]));
          check("move_y", int'(PlayerY), int'(em[12:3]));
          check("move_walk_frame", int'(walk_frame), int'(em[2:1]));
          check("move_moving", int'(moving), int'(em[0]));
        end
      end
    end
    last_pos = {PlayerX, PlayerY};
  end

  initial begin
    Reset    = 1'b1;
    vsync    = 1'b1;
    keycode  = 8'h00;
    wall_hit = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("reset_x", int'(PlayerX), 320);
    check("reset_y", int'(PlayerY), 240);
    check("reset_facing", int'(facing), 0);
    check("reset_moving", int'(moving), 0);
    check("reset_walk_frame", int'(walk_frame), 0);
    check("reset_query_valid", int'(query_valid), 0);
    @(negedge Clk);
    mon_en = 1'b1;

    // Clear step right: one tick issues the query, sixteen more move the sprite.
    push_query(21, 15);
    for (int i = 1; i <= 16; i++) push_move(320 + i, 240, (i / 4) % 4, (i < 16) ? 1 : 0);
    keycode = 8'h07;
    tick_frame();
    keycode = 8'h00;
    check("right_facing", int'(facing), 3);
    check("right_moving_started", int'(moving), 1);
    ticks(16);
    check("right_done_x", int'(PlayerX), 336);
    check("right_done_moving", int'(moving), 0);
    ticks(2);

    // Wall above: facing turns up, no walk.
    push_query(21, 14);
    keycode  = 8'h1A;
    wall_hit = 1'b1;
    tick_frame();
    keycode  = 8'h00;
    wall_hit = 1'b0;
    check("wall_facing", int'(facing), 1);
    check("wall_moving", int'(moving), 0);
    ticks(20);
    check("wall_y", int'(PlayerY), 240);

    // Walk left to column 0 with the key held, then press into the map edge.
    keycode = 8'h04;
    for (int s = 0; s <= 20; s++) begin
      push_query(20 - s, 15);
      for (int i = 1; i <= 16; i++)
        push_move((21 - s) * 16 - i, 240, (i / 4) % 4, (i < 16) ? 1 : 0);
    end
    ticks(21 * 17);
    check("edge_reached_x", int'(PlayerX), 0);
    ticks(5);
    keycode = 8'h00;
    check("edge_facing", int'(facing), 2);
    check("edge_x", int'(PlayerX), 0);
    check("edge_moving", int'(moving), 0);

    // Key released mid-step: the tile still completes.
    push_query(0, 16);
    for (int i = 1; i <= 16; i++) push_move(0, 240 + i, (i / 4) % 4, (i < 16) ? 1 : 0);
    keycode = 8'h16;
    ticks(5);
    keycode = 8'h00;
    ticks(12);
    check("release_y", int'(PlayerY), 256);
    check("release_moving", int'(moving), 0);
    // ty must now be 16: the next down query targets row 17 (blocked by a wall).
    push_query(0, 17);
    keycode  = 8'h16;
    wall_hit = 1'b1;
    tick_frame();
    keycode  = 8'h00;
    wall_hit = 1'b0;
    check("release_facing", int'(facing), 0);

    // Reset mid-walk after 7 moves of a right step.
    push_query(1, 16);
    for (int i = 1; i <= 7; i++) push_move(i, 256, (i / 4) % 4, 1);
    keycode = 8'h07;
    tick_frame();
    keycode = 8'h00;
    ticks(7);
    check("midwalk_x", int'(PlayerX), 7);
    push_move(320, 240, 0, 0);
    Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    check("midreset_x", int'(PlayerX), 320);
    check("midreset_moving", int'(moving), 0);
    check("midreset_facing", int'(facing), 0);
    wall_hit = 1'b1;
    @(negedge Clk) wall_hit = 1'b0;
    ticks(3);
    check("postreset_x", int'(PlayerX), 320);
    check("postreset_moving", int'(moving), 0);

    check("query_queue_empty", qq.size(), 0);
    check("move_queue_empty", mq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_walker.md
# tile_walker

Tile-locked player movement controller that replaces free-pixel ball motion for the overworld map. It sits between the USB keycode PIO output and the color mapper's sprite inputs. It converts W/A/S/D keycodes into one-tile steps, checks each target tile against the collision map ROM through a fixed-latency query port, and animates the step one pixel per video frame. Outputs feed the color mapper as sprite position, facing and walk-frame index.

## Interface
- TILE_SIZE, 16: tile edge in pixels (power of two, 8..32)
- MAP_W, 40: map width in tiles
- MAP_H, 30: map height in tiles
- START_TX, 20: reset tile column
- START_TY, 15: reset tile row
- ANIM_DIV, 4: frames per walk_frame advance (power of two)

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50 domain, same clock as vga_controller)
- Reset  in  1  synchronous, active-high
- vsync  in  1  raw VGA_VS from vga_controller, active-low pulse
- keycode  in  8  USB HID keycode (0x1A=W up, 0x16=S down, 0x04=A left, 0x07=D right, else none)
- query_valid  out  1  one-cycle pulse, collision lookup request
- query_tx  out  6  target tile column, held until next query
- query_ty  out  5  target tile row, held until next query
- wall_hit  in  1  collision ROM data, valid exactly 1 cycle after query_valid
- PlayerX  out  10  sprite top-left X pixel
- PlayerY  out  10  sprite top-left Y pixel
- facing  out  2  0=down 1=up 2=left 3=right
- walk_frame  out  2  animation frame index
- moving  out  1  high while in WALK

## Operation
- Frame tick: vs_q registers vsync; tick = vs_q & ~vsync (first cycle vsync reads low). One tick per frame.
- Registers: tx, ty (tile), PlayerX, PlayerY, step_cnt (log2 TILE_SIZE bits), anim_cnt, dir.
- Reset values: tx=START_TX, ty=START_TY, PlayerX=START_TX*TILE_SIZE (320), PlayerY=START_TY*TILE_SIZE (240), facing=0, walk_frame=0, moving=0, query_valid=0, query_tx=0, query_ty=0, state=IDLE, vs_q=1.
- States:
  - IDLE: on tick with a direction keycode, facing<=dir. If target tile is in bounds (tx-1>=0, tx+1<=MAP_W-1, ty-1>=0, ty+1<=MAP_H-1), load query_tx/ty with target, pulse query_valid, go QUERY; otherwise stay IDLE (facing still updates). A non-direction keycode or no tick does nothing.
  - QUERY: one cycle, go WAIT.
  - WAIT: sample wall_hit. If 1, go IDLE. If 0, go WALK with step_cnt=0, anim_cnt=0.
  - WALK: moving=1. On each tick, PlayerX/PlayerY moves 1 pixel in dir, step_cnt++, anim_cnt++. walk_frame increments when anim_cnt wraps at ANIM_DIV; it wraps 3->0. When the tick brings step_cnt to TILE_SIZE (wrap to 0), tx/ty<=target in that same cycle and state goes IDLE.
- On leaving WALK, walk_frame resets to 0.
- keycode is ignored outside IDLE-on-tick. Release or change mid-step does not abort; the tile always completes.
- Ticks during QUERY/WAIT are ignored (not queued).
- Invariant in IDLE: PlayerX==tx*TILE_SIZE, PlayerY==ty*TILE_SIZE.
- Reset asserted in any state restores reset values on the next edge. An in-flight query result is discarded.

## Timing
- Tick at cycle T in IDLE: facing, query_tx/ty and query_valid are visible at T+1 (state QUERY). wall_hit is sampled at T+2 (state WAIT). State is WALK or IDLE at T+3.
- First pixel move occurs on the next tick after entering WALK. A full step takes TILE_SIZE ticks after that (16 frames ≈ 267 ms at 60 Hz).
- A held key with a clear path steps every TILE_SIZE+1 frames. The completion tick cannot also start a new step.
- All outputs are registered. No combinational path from keycode to outputs.

## Test plan
- Reset: assert Reset for 2 cycles -> PlayerX=320, PlayerY=240, facing=0, moving=0, walk_frame=0, query_valid=0.
- Clear step right: keycode=0x07, wall_hit=0, issue 17 ticks -> query_valid pulse with query_tx=21, query_ty=15. PlayerX steps 321..336 then holds at 336. walk_frame sequence 0,1,2,3 every 4 ticks. moving drops after the 16th move.
- Wall: keycode=0x1A, wall_hit=1 at query+1 -> facing=1, no WALK, PlayerY stays 240 across 20 ticks.
- Map edge: walk to tx=0, keycode=0x04 -> facing=2, query_valid never pulses, PlayerX stays 0.
- Key release mid-step: keycode=0x16, set keycode=0x00 after 5 ticks -> step still completes at PlayerY=256, ty=16.
- Reset mid-walk: Reset after 7 ticks of a right step -> next cycle PlayerX=320, moving=0. Then a later wall_hit pulse has no effect.
